// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage of the pipeline. Selects the register-file write data,
// qualifies the write enable so that writes to register 0 are dropped, and
// keeps a one-entry hold/forwarding register together with a saturating
// count of retired writes.
//
// Ports
//   clk             rising-edge clock for all state
//   rst             synchronous, active-high reset
//   mem_control_wb  [1] MemtoReg, [0] RegWrite (from MEM/WB)
//   mem_read_data   load data from the memory stage
//   mem_alu_result  ALU result from the memory stage
//   mem_write_reg   destination register number
//   wb_data         write-back data (combinational)
//   wb_reg_write    qualified register-file write enable (combinational)
//   wb_write_reg    register-file write address (combinational)
//   hold_valid      a write retired in the previous cycle
//   hold_reg        destination of the last retired write
//   hold_data       data of the last retired write
//   wb_write_count  saturating count of retired writes
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_control_wb,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [REG_W-1:0]  mem_write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic              hold_valid,
    output logic [REG_W-1:0]  hold_reg,
    output logic [DATA_W-1:0] hold_data,
    output logic [CNT_W-1:0]  wb_write_count
);

    always_comb begin
        wb_data      = mem_control_wb[1] ? mem_read_data : mem_alu_result;
        wb_write_reg = mem_write_reg;
        // Register 0 is hard-wired to zero, so a write to it never retires.
        wb_reg_write = mem_control_wb[0] && (mem_write_reg != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid     <= 1'b0;
            hold_reg       <= '0;
            hold_data      <= '0;
            wb_write_count <= '0;
        end else begin
            hold_valid <= wb_reg_write;
            if (wb_reg_write) begin
                hold_reg  <= mem_write_reg;
                hold_data <= wb_data;
                if (wb_write_count != '1)
                    wb_write_count <= wb_write_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mem_control_wb;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] mem_alu_result;
    logic [REG_W-1:0]  mem_write_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_reg_write;
    logic [REG_W-1:0]  wb_write_reg;
    logic              hold_valid;
    logic [REG_W-1:0]  hold_reg;
    logic [DATA_W-1:0] hold_data;
    logic [CNT_W-1:0]  wb_write_count;

    wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_control_wb (mem_control_wb),
        .mem_read_data  (mem_read_data),
        .mem_alu_result (mem_alu_result),
        .mem_write_reg  (mem_write_reg),
        .wb_data        (wb_data),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .hold_valid     (hold_valid),
        .hold_reg       (hold_reg),
        .hold_data      (hold_data),
        .wb_write_count (wb_write_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic              m_valid;
    logic [REG_W-1:0]  m_reg;
    logic [DATA_W-1:0] m_data;
    int                m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
        chk("hold_valid", 64'(hold_valid), 64'(m_valid));
        chk("hold_reg", 64'(hold_reg), 64'(m_reg));
        chk("hold_data", 64'(hold_data), 64'(m_data));
        chk("count", 64'(wb_write_count), 64'(m_cnt));
    endtask

    // Called just after a rising edge: drive, check combinational outputs,
    // take one edge, advance the model, check the registered outputs.
    task automatic step(input logic r, input logic [1:0] ctl, input logic [DATA_W-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr);
        logic [DATA_W-1:0] e_data;
        logic              e_we;
        rst = r; mem_control_wb = ctl; mem_read_data = rd;
        mem_alu_result = alu; mem_write_reg = wr;
        e_data = (ctl == 2'b10 || ctl == 2'b11) ? rd : alu;
        e_we   = (ctl == 2'b01 || ctl == 2'b11) && (wr != 0);
        #2;
        chk("wb_data", 64'(wb_data), 64'(e_data));
        chk("wb_reg_write", 64'(wb_reg_write), 64'(e_we));
        chk("wb_write_reg", 64'(wb_write_reg), 64'(wr));
        // Wiggle inputs mid-cycle; registers must only see the edge values.
        mem_alu_result = ~alu; mem_read_data = ~rd;
        #2;
        mem_alu_result = alu; mem_read_data = rd;
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_reg = 0; m_data = 0; m_cnt = 0;
        end else begin
            m_valid = e_we;
            if (e_we) begin
                m_reg = wr; m_data = e_data;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
        #1;
        chk_regs();
    endtask

    initial begin
        // Combinational mux select while held in reset
        rst = 1'b1; mem_control_wb = 2'b00; mem_write_reg = '0;
        mem_read_data = 32'hAAAAAAAA; mem_alu_result = 32'h55555555;
        #1 chk("mux_00", 64'(wb_data), 64'h55555555);
        #10 mem_control_wb = 2'b10;
        #1 chk("mux_10", 64'(wb_data), 64'hAAAAAAAA);
        #10 mem_control_wb = 2'b00;
        #1 chk("mux_00b", 64'(wb_data), 64'h55555555);

        @(posedge clk); #1;
        m_valid = 0; m_reg = 0; m_data = 0; m_cnt = 0;
        chk_regs();

        step(0, 2'b11, 32'hAAAAAAAA, 32'h55555555, 5'd8);  // qualified write
        step(0, 2'b01, 32'hAAAAAAAA, 32'h55555555, 5'd0);  // reg 0 suppressed
        step(0, 2'b11, 32'hAAAAAAAA, 32'h55555555, 5'd8);
        step(1, 2'b01, 32'hAAAAAAAA, 32'h55555555, 5'd3);  // reset priority
        step(0, 2'b01, 32'hAAAAAAAA, 32'h55555555, 5'd8);  // write 0x5555 to r8
        step(0, 2'b00, 32'hAAAAAAAA, 32'h55555555, 5'd8);  // hold retention
        step(0, 2'b10, 32'h12345678, 32'h55555555, 5'd5);  // load without write
        for (int unsigned i = 0; i < CNT_MAX + 3; i++)     // saturation
            step(0, 2'b01, 32'h0, i, 5'(i % 31 + 1));

        for (int unsigned i = 0; i < 300; i++)
            step(($urandom_range(0, 19) == 0), 2'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
